// File: rtl/reg_file_4x4.sv
// Register file: DEPTH entries of WIDTH bits, one write port, two registered read ports.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset; clears storage and both read ports
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   re_a_i     read request, port A
//   raddr_a_i  read address, port A
//   rdata_a_o  registered read data, port A (holds when idle)
//   rvalid_a_o port A data valid, one pulse per request
//   re_b_i     read request, port B
//   raddr_b_i  read address, port B
//   rdata_b_o  registered read data, port B (holds when idle)
//   rvalid_b_o port B data valid, one pulse per request
module reg_file_4x4 #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_a_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  output logic              rvalid_a_o,
  input  logic              re_b_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_b_o,
  output logic              rvalid_b_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             rvalid_a_q, rvalid_a_d;
  logic             rvalid_b_q, rvalid_b_d;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Reads look at the post-write array, which gives write-to-read bypass
  // on an address match without a separate compare path.
  always_comb begin
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = re_a_i;
    rvalid_b_d = re_b_i;
    if (re_a_i) begin
      rdata_a_d = mem_d[raddr_a_i];
    end
    if (re_b_i) begin
      rdata_b_d = mem_d[raddr_b_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign rdata_a_o  = rdata_a_q;
  assign rdata_b_o  = rdata_b_q;
  assign rvalid_a_o = rvalid_a_q;
  assign rvalid_b_o = rvalid_b_q;

endmodule

// File: tb/tb_reg_file_4x4.sv
// Self-checking bench for reg_file_4x4: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a behavioural model.
module tb_reg_file_4x4;

  logic       clk = 1'b0;
  logic       rst, we, re_a, re_b;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [3:0] wdata;
  logic [3:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [3:0] m_mem [4];
  logic [3:0] m_rd_a, m_rd_b;
  logic       m_v_a, m_v_b;

  always #5 clk = ~clk;

  reg_file_4x4 dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .re_a_i     (re_a),
    .raddr_a_i  (raddr_a),
    .rdata_a_o  (rdata_a),
    .rvalid_a_o (rvalid_a),
    .re_b_i     (re_b),
    .raddr_b_i  (raddr_b),
    .rdata_b_o  (rdata_b),
    .rvalid_b_o (rvalid_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reset wins; otherwise a write lands first, so a same-cycle read sees it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_mem[i] = 4'h0;
      m_rd_a = 4'h0;
      m_rd_b = 4'h0;
      m_v_a  = 1'b0;
      m_v_b  = 1'b0;
    end else begin
      if (we) m_mem[waddr] = wdata;
      m_v_a = re_a;
      m_v_b = re_b;
      if (re_a) m_rd_a = m_mem[raddr_a];
      if (re_b) m_rd_b = m_mem[raddr_b];
    end
  end

  // Compare process: outputs settle after the rising edge, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata_a",  32'(rdata_a),  32'(m_rd_a));
      chk("rvalid_a", 32'(rvalid_a), 32'(m_v_a));
      chk("rdata_b",  32'(rdata_b),  32'(m_rd_b));
      chk("rvalid_b", 32'(rvalid_b), 32'(m_v_b));
    end
  end

  task automatic step(input logic r, input logic w, input logic [1:0] wa, input logic [3:0] wd,
                      input logic ra_en, input logic [1:0] ra,
                      input logic rb_en, input logic [1:0] rb);
    rst = r; we = w; waddr = wa; wdata = wd;
    re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  initial begin
    step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk_en = 1'b1;
    chk("reset rvalid_a", 32'(rvalid_a), 32'd0);
    chk("reset rdata_b", 32'(rdata_b), 32'd0);

    // Reset clears a preloaded entry; a read requested in the reset cycle gives no valid.
    step(1'b0, 1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 1'b0, 2'd0);
    chk("preload a", 32'(rdata_a), 32'hA);
    step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 1'b0, 2'd0);
    chk("rst valid a", 32'(rvalid_a), 32'd0);
    chk("rst data a", 32'(rdata_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'(i), 1'b0, 2'd0);
      chk("post-rst data", 32'(rdata_a), 32'h0);
      chk("post-rst valid", 32'(rvalid_a), 32'd1);
    end

    // Write/readback on both ports in one cycle.
    step(1'b0, 1'b1, 2'd0, 4'h1, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd1, 4'h5, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd3, 4'hF, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd3, 1'b1, 2'd0);
    chk("wr/rd a", 32'(rdata_a), 32'hF);
    chk("wr/rd b", 32'(rdata_b), 32'h1);
    chk("wr/rd va", 32'({rvalid_a, rvalid_b}), 32'd3);

    // Bypass: same-cycle write and read to addr1.
    step(1'b0, 1'b1, 2'd1, 4'hC, 1'b1, 2'd1, 1'b0, 2'd0);
    chk("bypass a", 32'(rdata_a), 32'hC);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 1'b0, 2'd0);
    chk("bypass persist", 32'(rdata_a), 32'hC);
    step(1'b0, 1'b1, 2'd1, 4'h5, 1'b0, 2'd0, 1'b0, 2'd0);

    // Streaming on port B, then drop the request.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_s [4];
      exp_s = '{4'h1, 4'h5, 4'hA, 4'hF};
      step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'(i));
      chk("stream data", 32'(rdata_b), 32'(exp_s[i]));
      chk("stream valid", 32'(rvalid_b), 32'd1);
    end
    idle();
    chk("stream drop valid", 32'(rvalid_b), 32'd0);
    chk("stream hold data", 32'(rdata_b), 32'hF);

    // Reset priority over write and read.
    step(1'b1, 1'b1, 2'd2, 4'h7, 1'b1, 2'd2, 1'b0, 2'd0);
    chk("rstprio valid", 32'(rvalid_a), 32'd0);
    chk("rstprio data", 32'(rdata_a), 32'd0);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 1'b0, 2'd0);
    chk("rstprio dropped wr", 32'(rdata_a), 32'h0);

    // Dual same-address read.
    step(1'b0, 1'b1, 2'd3, 4'h9, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd3, 1'b1, 2'd3);
    chk("dual a", 32'(rdata_a), 32'h9);
    chk("dual b", 32'(rdata_b), 32'h9);
    chk("dual valids", 32'({rvalid_a, rvalid_b}), 32'd3);

    // Dual same-address read with bypass.
    step(1'b0, 1'b1, 2'd0, 4'h6, 1'b1, 2'd0, 1'b1, 2'd0);
    chk("dual bypass a", 32'(rdata_a), 32'h6);
    chk("dual bypass b", 32'(rdata_b), 32'h6);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 40) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
           1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
